whandler_wr_slice: RTL

WHANDLER_WR_SLICE -- requirements
Module: whandler_wr_slice

---
 rtl/whandler_wr_slice.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/whandler_wr_slice.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : whandler_wr_slice                                            |
// | Description : Register slice between the 64-to-32 write handler and a     |
// |               32-bit write endpoint. AW and W are buffered in independent  |
// |               2-entry FIFOs, at most two writes are outstanding downstream |
// |               and responses pass through a one-entry B buffer.             |
// |               Optional timeout logic: WHANDLER_WR_SLICE_TIMEOUT_EN.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module whandler_wr_slice #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] u_awaddr,
  input  logic                  u_awvalid,
  output logic                  u_awready,
  input  logic [31:0]           u_wdata,
  input  logic [3:0]            u_wstrb,
  input  logic                  u_wvalid,
  output logic                  u_wready,
  output logic [1:0]            u_bresp,
  output logic                  u_bvalid,
  input  logic                  u_bready,
  output logic [ADDR_WIDTH-1:0] d_awaddr,
  output logic                  d_awvalid,
  input  logic                  d_awready,
  output logic [31:0]           d_wdata,
  output logic [3:0]            d_wstrb,
  output logic                  d_wvalid,
  input  logic                  d_wready,
  input  logic [1:0]            d_bresp,
  input  logic                  d_bvalid,
  output logic                  d_bready,
  output logic                  timeout_pulse
);

  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 4..65535");
  end

  // AW FIFO state; the head register drives d_awaddr directly
  logic [ADDR_WIDTH-1:0] r_aw_head, r_aw_tail;
  logic [1:0]            r_aw_cnt, w_aw_cnt_nxt;
  logic                  r_aw_rdy, r_aw_vld;
  logic                  w_aw_push, w_aw_pop, w_aw_gate;

  // W FIFO state; strobe and data travel together
  logic [35:0]           r_w_head, r_w_tail;
  logic [1:0]            r_w_cnt, w_w_cnt_nxt;
  logic                  r_w_rdy, r_w_vld;
  logic                  w_w_push, w_w_pop;

  // Outstanding tracking and response path
  logic [1:0]            r_outst, w_outst_nxt;
  logic                  w_outst_dec;
  logic                  r_live;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  w_d_bhs, w_drop_hs, w_b_load_d, w_b_clr;
  logic                  w_to_fire;
  logic [1:0]            w_drop, w_drop_nxt;

  assign u_awready = r_aw_rdy;
  assign u_wready  = r_w_rdy;
  assign d_awaddr  = r_aw_head;
  assign d_awvalid = r_aw_vld;
  assign {d_wstrb, d_wdata} = r_w_head;
  assign d_wvalid  = r_w_vld;
  assign u_bvalid  = r_bvalid;
  assign u_bresp   = r_bresp;

  assign w_aw_push = u_awvalid & r_aw_rdy;
  assign w_aw_pop  = r_aw_vld & d_awready;
  assign w_w_push  = u_wvalid & r_w_rdy;
  assign w_w_pop   = r_w_vld & d_wready;

  // Response buffer accepts when empty, when draining this cycle, or to discard a late response
  assign d_bready   = r_live & (~r_bvalid | u_bready | (w_drop != 2'd0));
  assign w_d_bhs    = d_bvalid & d_bready;
  assign w_drop_hs  = w_d_bhs & (w_drop != 2'd0);
  assign w_b_load_d = w_d_bhs & (w_drop == 2'd0);
  assign w_b_clr    = r_bvalid & u_bready;

  // FIFO occupancy next-state for both channels
  always_comb begin
    w_aw_cnt_nxt = r_aw_cnt;
    w_w_cnt_nxt  = r_w_cnt;
    if (w_aw_push && !w_aw_pop)      w_aw_cnt_nxt = r_aw_cnt + 2'd1;
    else if (!w_aw_push && w_aw_pop) w_aw_cnt_nxt = r_aw_cnt - 2'd1;
    if (w_w_push && !w_w_pop)        w_w_cnt_nxt  = r_w_cnt + 2'd1;
    else if (!w_w_push && w_w_pop)   w_w_cnt_nxt  = r_w_cnt - 2'd1;
  end

  // Outstanding count: issue adds one, a response (real or synthesized) removes one
  assign w_outst_dec = (w_b_load_d | w_to_fire) & (r_outst != 2'd0);
  always_comb begin
    w_outst_nxt = r_outst;
    if (w_aw_pop && !w_outst_dec)      w_outst_nxt = r_outst + 2'd1;
    else if (!w_aw_pop && w_outst_dec) w_outst_nxt = r_outst - 2'd1;
  end

  // Block new issues at two outstanding, or when a further timeout would overflow the drop counter
  assign w_aw_gate = (w_outst_nxt == 2'd2) |
                     (({1'b0, w_outst_nxt} + {1'b0, w_drop_nxt}) >= 3'd3);

  // AW FIFO storage, ready and valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_head <= '0;
      r_aw_tail <= '0;
      r_aw_cnt  <= 2'd0;
      r_aw_rdy  <= 1'b0;
      r_aw_vld  <= 1'b0;
    end else begin
      r_aw_cnt <= w_aw_cnt_nxt;
      r_aw_rdy <= (w_aw_cnt_nxt != 2'd2);
      // once presented, an address stays valid until taken regardless of the gate
      r_aw_vld <= (r_aw_vld & ~d_awready) | ((w_aw_cnt_nxt != 2'd0) & ~w_aw_gate);
      if (w_aw_pop) begin
        if (w_aw_push && r_aw_cnt == 2'd1) r_aw_head <= u_awaddr;
        else                               r_aw_head <= r_aw_tail;
      end else if (w_aw_push && r_aw_cnt == 2'd0) begin
        r_aw_head <= u_awaddr;
      end
      if (w_aw_push && !w_aw_pop && r_aw_cnt == 2'd1) r_aw_tail <= u_awaddr;
    end
  end

  // W FIFO storage, ready and valid registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_w_head <= '0;
      r_w_tail <= '0;
      r_w_cnt  <= 2'd0;
      r_w_rdy  <= 1'b0;
      r_w_vld  <= 1'b0;
    end else begin
      r_w_cnt <= w_w_cnt_nxt;
      r_w_rdy <= (w_w_cnt_nxt != 2'd2);
      r_w_vld <= (w_w_cnt_nxt != 2'd0);
      if (w_w_pop) begin
        if (w_w_push && r_w_cnt == 2'd1) r_w_head <= {u_wstrb, u_wdata};
        else                             r_w_head <= r_w_tail;
      end else if (w_w_push && r_w_cnt == 2'd0) begin
        r_w_head <= {u_wstrb, u_wdata};
      end
      if (w_w_push && !w_w_pop && r_w_cnt == 2'd1) r_w_tail <= {u_wstrb, u_wdata};
    end
  end

  // Outstanding counter and post-reset enable for d_bready
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outst <= 2'd0;
      r_live  <= 1'b0;
    end else begin
      r_outst <= w_outst_nxt;
      r_live  <= 1'b1;
    end
  end

  // One-entry B buffer: a downstream load has priority, a synthesized error fills an empty buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bvalid <= 1'b0;
      r_bresp  <= 2'b00;
    end else if (w_b_load_d) begin
      r_bvalid <= 1'b1;
      r_bresp  <= d_bresp;
    end else if (w_to_fire) begin
      r_bvalid <= 1'b1;
      r_bresp  <= c_RESP_SLVERR;
    end else if (w_b_clr) begin
      r_bvalid <= 1'b0;
    end
  end

`ifdef WHANDLER_WR_SLICE_TIMEOUT_EN
  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_timer;
  logic [1:0]  r_drop;
  logic        r_to_pulse;

  // Fire only into an empty buffer and never in a cycle where a real response arrives
  assign w_to_fire     = (r_timer == c_TO_LAST) & ~r_bvalid & ~w_d_bhs & (r_outst != 2'd0);
  assign w_drop        = r_drop;
  assign timeout_pulse = r_to_pulse;

  // Drop counter next-state: one per synthesized error, one off per discarded late response
  always_comb begin
    w_drop_nxt = r_drop;
    if (w_to_fire)      w_drop_nxt = r_drop + 2'd1;
    else if (w_drop_hs) w_drop_nxt = r_drop - 2'd1;
  end

  // Response timer: runs while writes are outstanding, saturates at terminal count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= 16'd0;
    end else if (w_d_bhs || r_outst == 2'd0 || w_to_fire) begin
      r_timer <= 16'd0;
    end else if (r_timer != c_TO_LAST) begin
      r_timer <= r_timer + 16'd1;
    end
  end

  // Drop counter and timeout strobe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop     <= 2'd0;
      r_to_pulse <= 1'b0;
    end else begin
      r_drop     <= w_drop_nxt;
      r_to_pulse <= w_to_fire;
    end
  end
`else
  assign w_to_fire     = 1'b0;
  assign w_drop        = 2'd0;
  assign w_drop_nxt    = 2'd0;
  assign timeout_pulse = 1'b0;
`endif

endmodule
`default_nettype wire
